rpu_ctrl: RTL and testbench

- Receive-path control FSM that sits directly ahead of the rpu field register stage.
- Accepts a decoded packet header from ibd_decoder and pulses lreg_vld so the register stage captures the header fields.
- Requests buffer space, tracks grant success or failure with bounded retry, then counts the packet's data flits into the granted buffer.
- Reports each packet as done or errored to downstream encoders and the AXI write master.

---
 rtl/rpu_ctrl_pkg.sv | 28 ++
 rtl/rpu_ctrl_if.sv | 35 +++
 rtl/rpu_retry_ctr.sv | 62 ++++++
 rtl/rpu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rpu_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rpu_ctrl_pkg.sv
// rpu_ctrl_pkg: shared definitions for the receive-path control block.
//   - NOU_FLIT_CNT_W : flit count / index width, taken from `NOU_FLIT_SZ_WIDTH
//   - rpu_state_e    : control FSM state encoding
//   - ERR_*          : err_code values reported alongside pkt_err
`ifndef NOU_FLIT_SZ_WIDTH
`define NOU_FLIT_SZ_WIDTH 8
`endif

package rpu_ctrl_pkg;

    localparam int NOU_FLIT_CNT_W = `NOU_FLIT_SZ_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_BACKOFF = 3'd2,
        ST_RECV    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } rpu_state_e;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_NOBUF      = 2'd1;
    localparam logic [1:0] ERR_EARLY_LAST = 2'd2;
    localparam logic [1:0] ERR_NO_LAST    = 2'd3;

endpackage

// File: rtl/rpu_ctrl_if.sv
// rpu_ctrl_if: header, buffer-grant, flit and completion signals of rpu_ctrl.
//   slave  modport : the control block (consumes header/grant/flits, produces
//                    ready/strobes/status)
//   master modport : the surrounding decoder / allocator / encoder side
interface rpu_ctrl_if #(
    parameter int FLIT_CNT_W = rpu_ctrl_pkg::NOU_FLIT_CNT_W
);
    logic                  hdr_vld;
    logic                  hdr_rdy;
    logic [FLIT_CNT_W-1:0] pkt_flit_num;
    logic                  lreg_vld;
    logic                  buf_req;
    logic                  gnt_buf_vld;
    logic                  gnt_buf_status;
    logic                  flit_vld;
    logic                  flit_last;
    logic                  flit_rdy;
    logic                  flit_wr_en;
    logic [FLIT_CNT_W-1:0] flit_wr_idx;
    logic                  pkt_done;
    logic                  pkt_err;
    logic [1:0]            err_code;

    modport slave (
        input  hdr_vld, pkt_flit_num, gnt_buf_vld, gnt_buf_status, flit_vld, flit_last,
        output hdr_rdy, lreg_vld, buf_req, flit_rdy, flit_wr_en, flit_wr_idx,
               pkt_done, pkt_err, err_code
    );

    modport master (
        output hdr_vld, pkt_flit_num, gnt_buf_vld, gnt_buf_status, flit_vld, flit_last,
        input  hdr_rdy, lreg_vld, buf_req, flit_rdy, flit_wr_en, flit_wr_idx,
               pkt_done, pkt_err, err_code
    );
endinterface

// File: rtl/rpu_retry_ctr.sv
// rpu_retry_ctr: refused-grant counter and backoff gap timer for rpu_ctrl.
//   clk, rstn   : clock, asynchronous active-low reset
//   clr         : new header accepted, restart both counters
//   fail        : grant came back with "no space"
//   gap_run     : FSM is waiting in BACKOFF, let the gap timer run down
//   retry_sat   : the next refused grant reaches RETRY_MAX
//   gap_expire  : current BACKOFF cycle is the last one of the gap
module rpu_retry_ctr #(
    parameter int RETRY_MAX = 4,
    parameter int RETRY_GAP = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic fail,
    input  logic gap_run,
    output logic retry_sat,
    output logic gap_expire
);

    localparam logic [4:0] RETRY_MAX_C = 5'(RETRY_MAX);
    localparam logic [3:0] RETRY_GAP_C = 4'(RETRY_GAP);

    logic [3:0] retry_cnt_r;
    logic [3:0] gap_cnt_r;

    // Refused-grant count, saturating at the 4-bit maximum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retry_cnt_r <= 4'd0;
        end else if (clr) begin
            retry_cnt_r <= 4'd0;
        end else if (fail && (retry_cnt_r != 4'hF)) begin
            retry_cnt_r <= retry_cnt_r + 4'd1;
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end

    // Gap timer, reloaded on every refused grant and counted down in BACKOFF.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gap_cnt_r <= 4'd0;
        end else if (clr) begin
            gap_cnt_r <= 4'd0;
        end else if (fail) begin
            gap_cnt_r <= RETRY_GAP_C;
        end else if (gap_run && (gap_cnt_r != 4'd0)) begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    // Flags: the count is compared one step ahead so the FSM can decide on
    // the same edge that records the refusal.
    always_comb begin
        retry_sat  = (({1'b0, retry_cnt_r} + 5'd1) >= RETRY_MAX_C);
        gap_expire = (gap_cnt_r <= 4'd1);
    end

endmodule

// File: rtl/rpu_ctrl.sv
// rpu_ctrl: receive-path control FSM ahead of the rpu field register stage.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : rpu_ctrl_if.slave
//               header handshake (hdr_vld/hdr_rdy/pkt_flit_num) + lreg_vld,
//               buffer request/grant (buf_req, gnt_buf_vld, gnt_buf_status),
//               flit intake (flit_vld/flit_last/flit_rdy) + buffer write
//               (flit_wr_en, flit_wr_idx), completion (pkt_done, pkt_err,
//               err_code).
module rpu_ctrl
    import rpu_ctrl_pkg::*;
#(
    parameter int FLIT_CNT_W = rpu_ctrl_pkg::NOU_FLIT_CNT_W,
    parameter int RETRY_MAX  = 4,
    parameter int RETRY_GAP  = 3
) (
    input  logic      clk,
    input  logic      rstn,
    rpu_ctrl_if.slave bus
);

    localparam logic GAP_ZERO = (RETRY_GAP == 0);

    rpu_state_e            state_r;
    rpu_state_e            state_nxt_s;
    logic                  run_r;
    logic [FLIT_CNT_W-1:0] flit_tot_r;
    logic [FLIT_CNT_W-1:0] idx_r;
    logic [1:0]            err_code_r;
    logic [1:0]            err_val_s;
    logic                  err_ld_s;
    logic                  hdr_rdy_s;
    logic                  hdr_hs_s;
    logic                  gnt_s;
    logic                  flit_acc_s;
    logic                  tot_zero_s;
    logic                  idx_last_s;
    logic                  retry_sat_s;
    logic                  gap_expire_s;

    // Handshake and index decode shared by the FSM and datapath.
    always_comb begin
        // run_r keeps hdr_rdy low while reset is asserted.
        hdr_rdy_s  = (state_r == ST_IDLE) && run_r;
        hdr_hs_s   = bus.hdr_vld && hdr_rdy_s;
        gnt_s      = bus.gnt_buf_vld && (state_r == ST_REQ);
        flit_acc_s = bus.flit_vld && ((state_r == ST_RECV) || (state_r == ST_DRAIN));
        tot_zero_s = (flit_tot_r == {FLIT_CNT_W{1'b0}});
        idx_last_s = (idx_r == (flit_tot_r - FLIT_CNT_W'(1)));
    end

    rpu_retry_ctr #(
        .RETRY_MAX (RETRY_MAX),
        .RETRY_GAP (RETRY_GAP)
    ) u_retry (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (hdr_hs_s),
        .fail       (gnt_s && bus.gnt_buf_status),
        .gap_run    (state_r == ST_BACKOFF),
        .retry_sat  (retry_sat_s),
        .gap_expire (gap_expire_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and error-code selection.
    always_comb begin
        state_nxt_s = state_r;
        err_ld_s    = 1'b0;
        err_val_s   = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (hdr_hs_s) state_nxt_s = ST_REQ;
                else          state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (gnt_s) begin
                    if (!bus.gnt_buf_status) begin
                        state_nxt_s = tot_zero_s ? ST_DONE : ST_RECV;
                    end else if (retry_sat_s) begin
                        err_ld_s    = 1'b1;
                        err_val_s   = ERR_NOBUF;
                        // Nothing to drain for an empty packet.
                        state_nxt_s = tot_zero_s ? ST_ERR : ST_DRAIN;
                    end else begin
                        state_nxt_s = GAP_ZERO ? ST_REQ : ST_BACKOFF;
                    end
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_BACKOFF: begin
                if (gap_expire_s) state_nxt_s = ST_REQ;
                else              state_nxt_s = ST_BACKOFF;
            end
            ST_RECV: begin
                if (flit_acc_s) begin
                    if (bus.flit_last) begin
                        if (idx_last_s) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            err_ld_s    = 1'b1;
                            err_val_s   = ERR_EARLY_LAST;
                            state_nxt_s = ST_ERR;
                        end
                    end else if (idx_last_s) begin
                        err_ld_s    = 1'b1;
                        err_val_s   = ERR_NO_LAST;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RECV;
                    end
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_DRAIN: begin
                if (flit_acc_s && bus.flit_last) state_nxt_s = ST_ERR;
                else                             state_nxt_s = ST_DRAIN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Packet datapath: flit total, write index, pending error code.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_r      <= 1'b0;
            flit_tot_r <= {FLIT_CNT_W{1'b0}};
            idx_r      <= {FLIT_CNT_W{1'b0}};
            err_code_r <= ERR_NONE;
        end else begin
            run_r <= 1'b1;
            if (hdr_hs_s) begin
                flit_tot_r <= bus.pkt_flit_num;
                idx_r      <= {FLIT_CNT_W{1'b0}};
            end else if (flit_acc_s && (state_r == ST_RECV)) begin
                flit_tot_r <= flit_tot_r;
                idx_r      <= idx_r + FLIT_CNT_W'(1);
            end else begin
                flit_tot_r <= flit_tot_r;
                idx_r      <= idx_r;
            end
            if (err_ld_s) err_code_r <= err_val_s;
            else          err_code_r <= err_code_r;
        end
    end

    // FSM outputs, decoded from state and the current handshakes.
    always_comb begin
        bus.hdr_rdy     = hdr_rdy_s;
        bus.lreg_vld    = hdr_hs_s;
        bus.buf_req     = (state_r == ST_REQ);
        bus.flit_rdy    = (state_r == ST_RECV) || (state_r == ST_DRAIN);
        bus.flit_wr_en  = bus.flit_vld && (state_r == ST_RECV);
        bus.flit_wr_idx = (state_r == ST_RECV) ? idx_r : {FLIT_CNT_W{1'b0}};
        bus.pkt_done    = (state_r == ST_DONE);
        bus.pkt_err     = (state_r == ST_ERR);
        bus.err_code    = (state_r == ST_ERR) ? err_code_r : ERR_NONE;
    end

endmodule

// File: tb/tb_rpu_ctrl.sv
// tb_rpu_ctrl: directed + randomized packets against a packet-level outcome model.
module tb_rpu_ctrl;

    localparam int W    = 8;
    localparam int RMAX = 4;
    localparam int RGAP = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    rpu_ctrl_if #(.FLIT_CNT_W(W)) bus ();

    rpu_ctrl #(
        .FLIT_CNT_W (W),
        .RETRY_MAX  (RMAX),
        .RETRY_GAP  (RGAP)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {bus.hdr_rdy, bus.lreg_vld, bus.buf_req, bus.flit_rdy, bus.flit_wr_en,
                bus.pkt_done, bus.pkt_err, bus.err_code, bus.flit_wr_idx};
    endfunction

    task automatic idle_in();
        bus.hdr_vld        = 1'b0;
        bus.pkt_flit_num   = '0;
        bus.gnt_buf_vld    = 1'b0;
        bus.gnt_buf_status = 1'b0;
        bus.flit_vld       = 1'b0;
        bus.flit_last      = 1'b0;
    endtask

    // One packet: n data flits, 'fails' refused grants first, grant given 'lat'
    // cycles into each request, flit_last on flit number last_pos (1-based).
    // abort_after >= 0 pulls reset once that many flits have been accepted.
    task automatic run_pkt(input int n, input int fails, input int lat,
                           input int last_pos, input int abort_after);
        int exp_res, exp_w, exp_grants;
        int lreg_n = 0, grants = 0, fails_seen = 0, req_cyc = 0, low_cnt = 0;
        int sent = 0, wr_n = 0, rdy_n = 0, evt_cyc = 0, pulse_cyc = 0;
        int got_done = 0, got_err = 0, got_code = 0;
        bit hs = 0, got = 0, after_fail = 0, cur_vld = 0, cur_last = 0, gnt_now;

        // Outcome model from the packet's rules.
        if (fails >= RMAX)      begin exp_res = 1; exp_w = 0;        end
        else if (n == 0)        begin exp_res = 0; exp_w = 0;        end
        else if (last_pos == n) begin exp_res = 0; exp_w = n;        end
        else if (last_pos < n)  begin exp_res = 2; exp_w = last_pos; end
        else                    begin exp_res = 3; exp_w = n;        end
        exp_grants = (fails >= RMAX) ? RMAX : fails + 1;

        bus.hdr_vld      = 1'b1;
        bus.pkt_flit_num = n[W-1:0];
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            if (bus.lreg_vld === 1'b1) lreg_n++;
            if (bus.hdr_rdy === 1'b1) hs = 1;
            @(posedge clk); #1;
        end
        bus.hdr_vld      = 1'b0;
        bus.pkt_flit_num = W'($urandom);
        chk("hdr_handshake", 32'(hs), 1);
        if (!hs) return;

        for (int c = 0; c < 3000 && !got; c++) begin
            if (abort_after >= 0 && sent == abort_after) begin
                bus.hdr_vld     = 1'b1;
                bus.flit_vld    = 1'b1;
                bus.gnt_buf_vld = 1'b1;
                rstn = 1'b0;
                #1;
                chk("rst_outs_immediate", 32'(outs()), 0);
                @(negedge clk);
                chk("rst_outs_held", 32'(outs()), 0);
                @(posedge clk); #1;
                idle_in();
                rstn = 1'b1;
                @(negedge clk);
                chk("rst_no_pulse", 32'({bus.pkt_done, bus.pkt_err}), 0);
                return;
            end
            gnt_now = (bus.buf_req === 1'b1) && (req_cyc >= lat);
            if (bus.buf_req === 1'b1) begin
                bus.gnt_buf_vld    = gnt_now;
                bus.gnt_buf_status = gnt_now ? (grants < fails) : 1'($urandom_range(0, 1));
            end else begin
                // stray grants outside a request must be ignored
                bus.gnt_buf_vld    = 1'($urandom_range(0, 1));
                bus.gnt_buf_status = 1'b0;
            end
            if (!cur_vld && sent < last_pos && $urandom_range(0, 3) != 0) begin
                cur_vld  = 1;
                cur_last = (sent + 1 == last_pos);
            end
            bus.flit_vld  = cur_vld;
            bus.flit_last = cur_vld ? cur_last : 1'b0;

            @(negedge clk);
            if (bus.lreg_vld === 1'b1) lreg_n++;
            if (bus.flit_rdy === 1'b1) rdy_n++;
            if (bus.buf_req === 1'b1) begin
                if (after_fail) begin
                    chk("backoff_gap", low_cnt, RGAP);
                    after_fail = 0;
                end
            end else if (after_fail) begin
                low_cnt++;
            end
            if (bus.buf_req === 1'b1 && bus.gnt_buf_vld === 1'b1) begin
                grants++;
                req_cyc = 0;
                evt_cyc = cyc;
                if (bus.gnt_buf_status === 1'b1) begin
                    fails_seen++;
                    if (fails_seen < RMAX) begin
                        after_fail = 1;
                        low_cnt    = 0;
                    end
                end
            end else if (bus.buf_req === 1'b1) begin
                req_cyc++;
            end else begin
                req_cyc = 0;
            end
            if (bus.flit_vld === 1'b1 && bus.flit_rdy === 1'b1) begin
                sent++;
                cur_vld = 0;
                evt_cyc = cyc;
            end
            if (bus.flit_wr_en === 1'b1) begin
                chk("wr_idx", 32'(bus.flit_wr_idx), wr_n % 256);
                wr_n++;
            end
            if (bus.pkt_done === 1'b1 || bus.pkt_err === 1'b1) begin
                got       = 1;
                got_done  = 32'(bus.pkt_done);
                got_err   = 32'(bus.pkt_err);
                got_code  = 32'(bus.err_code);
                pulse_cyc = cyc;
            end
            @(posedge clk); #1;
        end

        chk("pkt_finished", 32'(got), 1);
        chk("pkt_done", got_done, 32'(exp_res == 0));
        chk("pkt_err", got_err, 32'(exp_res != 0));
        chk("err_code", got_code, exp_res);
        chk("pulse_latency", pulse_cyc - evt_cyc, 1);
        chk("writes", wr_n, exp_w);
        chk("flits_taken", sent, last_pos);
        chk("grants", grants, exp_grants);
        chk("lreg_pulses", lreg_n, 1);
        if (n == 0) chk("no_flit_rdy", rdy_n, 0);
        idle_in();
        @(negedge clk);
        chk("pulse_one_cycle", 32'({bus.pkt_done, bus.pkt_err}), 0);
        chk("hdr_rdy_after", 32'(bus.hdr_rdy), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        idle_in();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        run_pkt(3, 0, 2, 3, -1);     // normal 3-flit packet, grant 2 cycles in
        run_pkt(0, 0, 1, 0, -1);     // empty packet
        run_pkt(5, 4, 1, 5, -1);     // four refusals -> drained, no buffer
        run_pkt(4, 0, 0, 2, -1);     // early last
        run_pkt(2, 0, 1, 5, -1);     // missing last
        run_pkt(4, 0, 0, 4, 1);      // reset mid-RECV at idx 1
        run_pkt(3, 0, 0, 3, -1);     // clean packet after reset
        run_pkt(0, 5, 0, 0, -1);     // empty packet, no buffer
        run_pkt(2, 3, 0, 2, -1);     // granted on the last allowed retry
        run_pkt(1, 0, 0, 1, -1);     // single flit
        run_pkt(255, 0, 0, 255, -1); // largest packet

        for (int k = 0; k < 25; k++) begin
            int n, f, l, kind;
            n    = $urandom_range(0, 12);
            f    = $urandom_range(0, 5);
            kind = $urandom_range(0, 2);
            if (n == 0)         l = 0;
            else if (kind == 0) l = n;
            else if (kind == 1) l = $urandom_range(1, n);
            else                l = n + $urandom_range(1, 3);
            run_pkt(n, f, $urandom_range(0, 3), l, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
